// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle control FSM for the P1 datapath.
// Sequences the shared ALU through fetch/decode/execute/memory/writeback,
// drives ALU op, operand selects, flag write and all datapath enables.
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   Op, Funct          instruction register fields IR[31:26], IR[5:0]
//   Zero, Overflow     combinational ALU status for the current cycle
//   MemReady           memory finishes the current access this cycle
//   ALUOp..RegWrite    datapath control (combinational decode of State)
//   Illegal, State     FSM in ILLEGAL state, current state (debug)
module mc_ctrl #(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Overflow,
    input  logic       MemReady,
    output logic [2:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ExtOp,
    output logic       FlagWrite,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_WB_ALU   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SRAV = 6'b000111;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_LESS = 3'd4;
    localparam logic [2:0] ALU_B    = 3'd5;
    localparam logic [2:0] ALU_SAR  = 3'd6;

    state_t     r_state;
    state_t     w_state_next;
    state_t     w_bad;
    logic       r_ovf_q;
    logic       w_ovf_next;
    logic       w_r_legal;
    logic       w_r_signed;
    logic [2:0] w_r_aluop;
    logic       w_flag_write;
    logic       w_pc_write;
    logic       w_ir_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_reg_write;

    // Destination for an unsupported instruction
    assign w_bad = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;

    // R-type funct decode: legality, ALU op, and whether overflow matters
    always_comb begin
        w_r_legal  = 1'b1;
        w_r_signed = 1'b0;
        w_r_aluop  = ALU_ADD;
        case (Funct)
            F_ADD:  w_r_signed = 1'b1;
            F_ADDU: w_r_aluop  = ALU_ADD;
            F_SUB:  begin w_r_aluop = ALU_SUB; w_r_signed = 1'b1; end
            F_SUBU: w_r_aluop  = ALU_SUB;
            F_AND:  w_r_aluop  = ALU_AND;
            F_OR:   w_r_aluop  = ALU_OR;
            F_SLT:  w_r_aluop  = ALU_LESS;
            F_SRAV: w_r_aluop  = ALU_SAR;
            default: w_r_legal = 1'b0;
        endcase
    end

    // State register and latched overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_ovf_q <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ovf_q <= w_ovf_next;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_next = r_state;
        w_ovf_next   = r_ovf_q;
        ALUOp        = ALU_ADD;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ExtOp        = 2'b00;
        PCSrc        = 2'b00;
        IorD         = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        Illegal      = 1'b0;
        w_flag_write = 1'b0;
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                ALUSrcB    = 2'b01;
                w_ir_write = MemReady;
                w_pc_write = MemReady;
                w_ovf_next = 1'b0;
                if (MemReady) w_state_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                ALUSrcB = 2'b11;
                case (Op)
                    OP_R:                            w_state_next = w_r_legal ? S_EXEC_R : w_bad;
                    OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: w_state_next = S_EXEC_I;
                    OP_LW, OP_SW:                    w_state_next = S_MEM_ADDR;
                    OP_BEQ:                          w_state_next = S_BRANCH;
                    OP_J:                            w_state_next = S_JUMP;
                    default:                         w_state_next = w_bad;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA      = 1'b1;
                w_flag_write = 1'b1;
                ALUOp        = w_r_aluop;
                w_ovf_next   = Overflow & w_r_signed;
                w_state_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_flag_write = 1'b1;
                w_ovf_next   = 1'b0;
                case (Op)
                    OP_ADDI: w_ovf_next = Overflow;
                    OP_ORI:  begin ALUOp = ALU_OR; ExtOp = 2'b01; end
                    OP_LUI:  begin ALUOp = ALU_B;  ExtOp = 2'b10; end
                    default: ALUOp = ALU_ADD;
                endcase
                w_state_next = S_WB_ALU;
            end
            S_WB_ALU: begin
                // Signed overflow suppresses the register write
                w_reg_write  = ~r_ovf_q;
                RegDst       = (Op == OP_R);
                w_state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                w_state_next = (Op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_read = 1'b1;
                IorD       = 1'b1;
                if (MemReady) w_state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                MemToReg     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_write = 1'b1;
                IorD        = 1'b1;
                if (MemReady) w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA      = 1'b1;
                ALUOp        = ALU_SUB;
                w_flag_write = 1'b1;
                PCSrc        = 2'b01;
                w_pc_write   = Zero;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                PCSrc        = 2'b10;
                w_pc_write   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal      = 1'b1;
                w_state_next = S_ILLEGAL;
            end
            default: w_state_next = S_FETCH;
        endcase
    end

    // Enables and requests are forced low while reset is asserted
    assign FlagWrite = w_flag_write & rst_n;
    assign PCWrite   = w_pc_write   & rst_n;
    assign IRWrite   = w_ir_write   & rst_n;
    assign MemRead   = w_mem_read   & rst_n;
    assign MemWrite  = w_mem_write  & rst_n;
    assign RegWrite  = w_reg_write  & rst_n;
    assign State     = r_state;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;

    localparam int MAX_CYC = 40;
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
        ST_EXEC_I = 4'd3, ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WB = 4'd6,
        ST_MEM_WR = 4'd7, ST_WB_ALU = 4'd8, ST_BRANCH = 4'd9, ST_JUMP = 4'd10,
        ST_ILLEGAL = 4'd15;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [5:0] Op = 6'd0, Funct = 6'd0;
    logic Zero = 1'b0, Overflow = 1'b0, MemReady = 1'b0;
    logic [2:0] ALUOp;
    logic ALUSrcA, FlagWrite, PCWrite, IRWrite, MemRead, MemWrite, IorD;
    logic RegDst, MemToReg, RegWrite, Illegal;
    logic [1:0] ALUSrcB, ExtOp, PCSrc;
    logic [3:0] State;

    mc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
        .Overflow(Overflow), .MemReady(MemReady), .ALUOp(ALUOp),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .FlagWrite(FlagWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .RegDst(RegDst), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st; logic [2:0] aluop; logic srca; logic [1:0] srcb;
        logic [1:0] extop; logic fw; logic pcw; logic [1:0] pcsrc;
        logic irw; logic mr; logic mw; logic iord; logic regdst;
        logic m2r; logic rw; logic ill;
    } cap_t;

    typedef struct { logic [3:0] st; logic rdy; } step_t;

    // cls: 0=R 1=I 2=lw 3=sw 4=beq 5=j 6=illegal
    typedef struct {
        logic [5:0] op; logic [5:0] funct; int cls;
        logic [2:0] aluop; logic [1:0] extop; logic ovf_en;
    } instr_t;

    cap_t  cap [0:MAX_CYC-1];
    step_t exp_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    function automatic instr_t get_instr(input int idx);
        instr_t t;
        t.funct = 6'($urandom); t.extop = 2'b00; t.aluop = 3'd0; t.ovf_en = 1'b0;
        t.op = 6'b000000; t.cls = 0;
        case (idx)
            0:  begin t.funct = 6'b100000; t.ovf_en = 1'b1; end
            1:  t.funct = 6'b100001;
            2:  begin t.funct = 6'b100010; t.aluop = 3'd1; t.ovf_en = 1'b1; end
            3:  begin t.funct = 6'b100011; t.aluop = 3'd1; end
            4:  begin t.funct = 6'b100100; t.aluop = 3'd2; end
            5:  begin t.funct = 6'b100101; t.aluop = 3'd3; end
            6:  begin t.funct = 6'b101010; t.aluop = 3'd4; end
            7:  begin t.funct = 6'b000111; t.aluop = 3'd6; end
            8:  begin t.op = 6'b001000; t.cls = 1; t.ovf_en = 1'b1; end
            9:  begin t.op = 6'b001001; t.cls = 1; end
            10: begin t.op = 6'b001101; t.cls = 1; t.aluop = 3'd3; t.extop = 2'b01; end
            11: begin t.op = 6'b001111; t.cls = 1; t.aluop = 3'd5; t.extop = 2'b10; end
            12: begin t.op = 6'b100011; t.cls = 2; end
            13: begin t.op = 6'b101011; t.cls = 3; end
            14: begin t.op = 6'b000100; t.cls = 4; t.aluop = 3'd1; end
            15: begin t.op = 6'b000010; t.cls = 5; end
            default: begin t.op = 6'b111111; t.cls = 6; end
        endcase
        return t;
    endfunction

    // Reference phase sequence for one instruction, with the MemReady to drive per cycle
    task automatic push(input logic [3:0] st, input logic rdy);
        step_t s;
        s.st = st; s.rdy = rdy;
        exp_q.push_back(s);
    endtask

    task automatic build_exp(input int cls, input int wf, input int wr);
        exp_q.delete();
        for (int k = 0; k < wf; k++) push(ST_FETCH, 1'b0);
        push(ST_FETCH, 1'b1);
        push(ST_DECODE, 1'($urandom));
        case (cls)
            0: begin push(ST_EXEC_R, 1'($urandom)); push(ST_WB_ALU, 1'($urandom)); end
            1: begin push(ST_EXEC_I, 1'($urandom)); push(ST_WB_ALU, 1'($urandom)); end
            2: begin
                push(ST_MEM_ADDR, 1'($urandom));
                for (int k = 0; k < wr; k++) push(ST_MEM_RD, 1'b0);
                push(ST_MEM_RD, 1'b1);
                push(ST_MEM_WB, 1'($urandom));
            end
            3: begin
                push(ST_MEM_ADDR, 1'($urandom));
                for (int k = 0; k < wr; k++) push(ST_MEM_WR, 1'b0);
                push(ST_MEM_WR, 1'b1);
            end
            4: push(ST_BRANCH, 1'($urandom));
            5: push(ST_JUMP, 1'($urandom));
            default: for (int k = 0; k < MAX_CYC; k++) push(ST_ILLEGAL, 1'($urandom));
        endcase
    endtask

    // Drive one instruction until the DUT returns to FETCH (bounded), capturing outputs
    task automatic run_instr(input instr_t t, input logic ovf, input logic z, output int ncyc);
        bit left = 0;
        int i = 0;
        Op = t.op; Funct = t.funct; Overflow = ovf; Zero = z;
        while (i < MAX_CYC) begin
            if (State != ST_FETCH) left = 1;
            else if (left) break;
            MemReady = (i < exp_q.size()) ? exp_q[i].rdy : 1'b1;
            @(negedge clk);
            cap[i] = {State, ALUOp, ALUSrcA, ALUSrcB, ExtOp, FlagWrite, PCWrite, PCSrc,
                      IRWrite, MemRead, MemWrite, IorD, RegDst, MemToReg, RegWrite, Illegal};
            i++;
            @(posedge clk); #1;
        end
        ncyc = i;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; MemReady = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (State !== 4'd0 || {FlagWrite, PCWrite, IRWrite, MemRead, MemWrite, RegWrite} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d State=%0d en=%b expected State=0 en=000000", k, State,
                         {FlagWrite, PCWrite, IRWrite, MemRead, MemWrite, RegWrite});
            end
        end
        @(posedge clk); #2;
        MemReady = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (MemRead !== 1'b1 || State !== 4'd0 || IRWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release MemRead=%b State=%0d IRWrite=%b expected 1/0/0", MemRead, State, IRWrite);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_ovf();
        int n;
        build_exp(0, 0, 0); run_instr(get_instr(0), 1'b1, 1'b0, n);
        n_checks++;
        if (n !== 4 || cap[2].aluop !== 3'd0 || cap[2].fw !== 1'b1 || cap[3].rw !== 1'b0) begin
            n_fail++;
            $display("FAIL add_ovf cycles=%0d aluop=%0d fw=%b rw=%b expected 4/0/1/0", n, cap[2].aluop, cap[2].fw, cap[3].rw);
        end
        build_exp(0, 0, 0); run_instr(get_instr(1), 1'b1, 1'b0, n);
        n_checks++;
        if (n !== 4 || cap[3].rw !== 1'b1 || cap[3].regdst !== 1'b1) begin
            n_fail++;
            $display("FAIL addu_ovf cycles=%0d rw=%b regdst=%b expected 4/1/1", n, cap[3].rw, cap[3].regdst);
        end
    endtask

    task automatic test_lw_wait();
        int n;
        int rd = 0;
        build_exp(2, 0, 2); run_instr(get_instr(12), 1'b0, 1'b0, n);
        for (int k = 0; k < n; k++) if (cap[k].st == ST_MEM_RD) rd++;
        n_checks++;
        if (n !== 7 || rd !== 3 || cap[6].st !== ST_MEM_WB || cap[6].rw !== 1'b1 || cap[6].m2r !== 1'b1) begin
            n_fail++;
            $display("FAIL lw_wait cycles=%0d rd_cycles=%0d st6=%0d rw=%b m2r=%b expected 7/3/6/1/1",
                     n, rd, cap[6].st, cap[6].rw, cap[6].m2r);
        end
    endtask

    task automatic test_beq();
        int n;
        for (int z = 1; z >= 0; z--) begin
            build_exp(4, 0, 0); run_instr(get_instr(14), 1'b0, 1'(z), n);
            n_checks++;
            if (n !== 3 || cap[2].st !== ST_BRANCH || cap[2].pcw !== 1'(z) || cap[2].pcsrc !== 2'b01 ||
                State !== ST_FETCH) begin
                n_fail++;
                $display("FAIL beq_z%0d cycles=%0d st=%0d pcw=%b pcsrc=%b expected 3/9/%0d/01", z, n,
                         cap[2].st, cap[2].pcw, cap[2].pcsrc, z);
            end
        end
    endtask

    task automatic test_lui_srav();
        int n;
        build_exp(1, 0, 0); run_instr(get_instr(11), 1'b0, 1'b0, n);
        n_checks++;
        if (cap[2].aluop !== 3'd5 || cap[2].extop !== 2'b10 || cap[3].regdst !== 1'b0 || cap[3].rw !== 1'b1) begin
            n_fail++;
            $display("FAIL lui aluop=%0d extop=%b regdst=%b rw=%b expected 5/10/0/1", cap[2].aluop,
                     cap[2].extop, cap[3].regdst, cap[3].rw);
        end
        build_exp(0, 0, 0); run_instr(get_instr(7), 1'b0, 1'b0, n);
        n_checks++;
        if (cap[2].aluop !== 3'd6 || cap[2].srca !== 1'b1) begin
            n_fail++;
            $display("FAIL srav aluop=%0d srca=%b expected 6/1", cap[2].aluop, cap[2].srca);
        end
    endtask

    task automatic test_random();
        int n, wf, wr, rw_c, mr_c, mw_c, fw_c, pcw_c, irw_c, e_rw, e_mr, e_mw, e_fw, e_pcw, bad;
        instr_t t;
        logic ovf, z;
        for (int it = 0; it < 80; it++) begin
            t = get_instr(int'($urandom_range(0, 15)));
            wf = int'($urandom_range(0, 2)); wr = int'($urandom_range(0, 2));
            ovf = 1'($urandom); z = 1'($urandom);
            build_exp(t.cls, wf, wr);
            run_instr(t, ovf, z, n);
            bad = 0; rw_c = 0; mr_c = 0; mw_c = 0; fw_c = 0; pcw_c = 0; irw_c = 0;
            for (int k = 0; k < n; k++) begin
                if (k >= exp_q.size() || cap[k].st !== exp_q[k].st) bad++;
                rw_c += int'(cap[k].rw); mr_c += int'(cap[k].mr); mw_c += int'(cap[k].mw);
                fw_c += int'(cap[k].fw); pcw_c += int'(cap[k].pcw); irw_c += int'(cap[k].irw);
            end
            n_checks++;
            if (n !== exp_q.size() || bad !== 0) begin
                n_fail++;
                $display("FAIL rnd_seq it=%0d op=%b cycles=%0d bad_states=%0d expected cycles=%0d bad=0",
                         it, t.op, n, bad, exp_q.size());
            end
            e_rw  = (t.cls <= 1) ? int'(!(ovf && t.ovf_en)) : (t.cls == 2 ? 1 : 0);
            e_mr  = wf + 1 + (t.cls == 2 ? wr + 1 : 0);
            e_mw  = (t.cls == 3) ? wr + 1 : 0;
            e_fw  = (t.cls <= 1 || t.cls == 4) ? 1 : 0;
            e_pcw = 1 + ((t.cls == 4) ? int'(z) : 0) + ((t.cls == 5) ? 1 : 0);
            n_checks++;
            if (rw_c !== e_rw || mr_c !== e_mr || mw_c !== e_mw || fw_c !== e_fw || pcw_c !== e_pcw || irw_c !== 1) begin
                n_fail++;
                $display("FAIL rnd_enables it=%0d op=%b rw/mr/mw/fw/pcw/irw=%0d/%0d/%0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d/%0d/1",
                         it, t.op, rw_c, mr_c, mw_c, fw_c, pcw_c, irw_c, e_rw, e_mr, e_mw, e_fw, e_pcw);
            end
            if (t.cls <= 1 || t.cls == 4) begin
                n_checks++;
                if (cap[wf+2].aluop !== t.aluop || (t.cls == 1 && cap[wf+2].extop !== t.extop) ||
                    (t.cls == 0 && cap[wf+3].regdst !== 1'b1)) begin
                    n_fail++;
                    $display("FAIL rnd_aluop it=%0d op=%b funct=%b aluop=%0d extop=%b expected aluop=%0d extop=%b",
                             it, t.op, t.funct, cap[wf+2].aluop, cap[wf+2].extop, t.aluop, t.extop);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int n;
        int ok = 0;
        build_exp(6, 0, 0); run_instr(get_instr(16), 1'b0, 1'b0, n);
        for (int k = 2; k < 12; k++) if (cap[k].st == ST_ILLEGAL && cap[k].ill == 1'b1) ok++;
        n_checks++;
        if (ok !== 10 || cap[5].mr !== 1'b0 || cap[5].pcw !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_hold ok_cycles=%0d mr=%b pcw=%b expected 10/0/0", ok, cap[5].mr, cap[5].pcw);
        end
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (State !== ST_FETCH || Illegal !== 1'b0 || MemRead !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_async_reset State=%0d Illegal=%b MemRead=%b expected 0/0/0", State, Illegal, MemRead);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_lw_wait();
        test_beq();
        test_lui_srav();
        test_random();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
